// File: rtl/axi4lite_apb_bridge_if.sv
// Bus interfaces for the AXI4-Lite to APB3 bridge: the AXI4-Lite side and the
// APB3 side, each with master/slave modports.
//
// Handshake semantics (AXI side): a transfer on a channel happens on the rising
// clock edge where both valid and ready are high. A master that has raised
// valid keeps it, and its payload, stable until that edge. The bridge is
// allowed to raise ready only while it is idle.
interface axi4lite_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

interface apb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic              psel;
    logic              penable;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output paddr, pwrite, pwdata, psel, penable,
        input  prdata, pready, pslverr
    );
    modport slave (
        input  paddr, pwrite, pwdata, psel, penable,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/axi4lite_apb_bridge.sv
// AXI4-Lite slave to APB3 master bridge with a single outstanding transaction.
// Reads and writes are arbitrated round-robin in IDLE; out-of-range addresses
// and partial write strobes are answered locally without an APB access; a
// stalled APB slave is abandoned after TIMEOUT ACCESS cycles.
module axi4lite_apb_bridge #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int ADDR_LIMIT = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic       pclk,
    input  logic       presetn,
    axi4lite_if.slave  s_axi,
    apb_if.master      m_apb,
    output logic [2:0] o_state
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ACCESS = 3'd2,
        S_WRESP  = 3'd3,
        S_RRESP  = 3'd4
    } state_t;

    localparam int                  CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [ADDR_W-1:0]   LIMIT    = ADDR_W'(ADDR_LIMIT);
    localparam logic [DATA_W/8-1:0] STRB_ALL = '1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rr_last_read;

    logic             w_wr_cand;
    logic             w_rd_cand;
    logic             w_pick_wr;
    logic             w_pick_rd;
    logic             w_wr_hs;
    logic             w_rd_hs;
    logic [CNT_W-1:0] w_cnt_next;

    assign o_state = r_state;

    // Arbitration: a write needs both address and data; on a tie the type not
    // served last wins. Ready is raised one cycle ahead, so the choice is
    // made whenever the FSM is about to be (or stays) idle.
    always_comb begin
        w_wr_cand  = s_axi.awvalid & s_axi.wvalid;
        w_rd_cand  = s_axi.arvalid;
        w_pick_wr  = w_wr_cand & (~w_rd_cand | r_rr_last_read);
        w_pick_rd  = w_rd_cand & ~w_pick_wr;
        w_wr_hs    = s_axi.awready & s_axi.wready & s_axi.awvalid & s_axi.wvalid;
        w_rd_hs    = s_axi.arready & s_axi.arvalid;
        w_cnt_next = r_cnt + CNT_W'(1);
    end

    // Bridge FSM with all bus outputs registered.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_rr_last_read  <= 1'b1;
            s_axi.awready   <= 1'b0;
            s_axi.wready    <= 1'b0;
            s_axi.arready   <= 1'b0;
            s_axi.bvalid    <= 1'b0;
            s_axi.bresp     <= 2'b00;
            s_axi.rvalid    <= 1'b0;
            s_axi.rresp     <= 2'b00;
            s_axi.rdata     <= '0;
            m_apb.psel      <= 1'b0;
            m_apb.penable   <= 1'b0;
            m_apb.paddr     <= '0;
            m_apb.pwrite    <= 1'b0;
            m_apb.pwdata    <= '0;
        end else begin
            // Ready strobes are single-cycle pulses unless re-armed below.
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b0;
            s_axi.arready <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_wr_hs) begin
                        r_rr_last_read <= 1'b0;
                        if (s_axi.awaddr >= LIMIT) begin
                            s_axi.bvalid <= 1'b1;
                            s_axi.bresp  <= RESP_DECERR;
                            r_state      <= S_WRESP;
                        end else if (s_axi.wstrb != STRB_ALL) begin
                            s_axi.bvalid <= 1'b1;
                            s_axi.bresp  <= RESP_SLVERR;
                            r_state      <= S_WRESP;
                        end else begin
                            m_apb.psel    <= 1'b1;
                            m_apb.penable <= 1'b0;
                            m_apb.paddr   <= s_axi.awaddr;
                            m_apb.pwrite  <= 1'b1;
                            m_apb.pwdata  <= s_axi.wdata;
                            r_cnt         <= '0;
                            r_state       <= S_SETUP;
                        end
                    end else if (w_rd_hs) begin
                        r_rr_last_read <= 1'b1;
                        if (s_axi.araddr >= LIMIT) begin
                            s_axi.rvalid <= 1'b1;
                            s_axi.rresp  <= RESP_DECERR;
                            s_axi.rdata  <= '0;
                            r_state      <= S_RRESP;
                        end else begin
                            m_apb.psel    <= 1'b1;
                            m_apb.penable <= 1'b0;
                            m_apb.paddr   <= s_axi.araddr;
                            m_apb.pwrite  <= 1'b0;
                            r_cnt         <= '0;
                            r_state       <= S_SETUP;
                        end
                    end else begin
                        s_axi.awready <= w_pick_wr;
                        s_axi.wready  <= w_pick_wr;
                        s_axi.arready <= w_pick_rd;
                    end
                end

                S_SETUP: begin
                    m_apb.penable <= 1'b1;
                    r_state       <= S_ACCESS;
                end

                S_ACCESS: begin
                    if (m_apb.pready) begin
                        m_apb.psel    <= 1'b0;
                        m_apb.penable <= 1'b0;
                        if (m_apb.pwrite) begin
                            s_axi.bvalid <= 1'b1;
                            s_axi.bresp  <= m_apb.pslverr ? RESP_SLVERR : RESP_OKAY;
                            r_state      <= S_WRESP;
                        end else begin
                            s_axi.rvalid <= 1'b1;
                            s_axi.rresp  <= m_apb.pslverr ? RESP_SLVERR : RESP_OKAY;
                            s_axi.rdata  <= m_apb.prdata;
                            r_state      <= S_RRESP;
                        end
                    end else if (w_cnt_next == CNT_MAX) begin
                        // Slave never answered: abandon the access. Once psel
                        // is low any late pready is simply not looked at.
                        m_apb.psel    <= 1'b0;
                        m_apb.penable <= 1'b0;
                        r_cnt         <= w_cnt_next;
                        if (m_apb.pwrite) begin
                            s_axi.bvalid <= 1'b1;
                            s_axi.bresp  <= RESP_SLVERR;
                            r_state      <= S_WRESP;
                        end else begin
                            s_axi.rvalid <= 1'b1;
                            s_axi.rresp  <= RESP_SLVERR;
                            s_axi.rdata  <= '0;
                            r_state      <= S_RRESP;
                        end
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end

                S_WRESP: begin
                    if (s_axi.bready) begin
                        s_axi.bvalid  <= 1'b0;
                        s_axi.bresp   <= 2'b00;
                        s_axi.awready <= w_pick_wr;
                        s_axi.wready  <= w_pick_wr;
                        s_axi.arready <= w_pick_rd;
                        r_state       <= S_IDLE;
                    end
                end

                S_RRESP: begin
                    if (s_axi.rready) begin
                        s_axi.rvalid  <= 1'b0;
                        s_axi.rresp   <= 2'b00;
                        s_axi.rdata   <= '0;
                        s_axi.awready <= w_pick_wr;
                        s_axi.wready  <= w_pick_wr;
                        s_axi.arready <= w_pick_rd;
                        r_state       <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
